addsub_checker: RTL and testbench
=================================

ADDSUB_CHECKER -- requirements
Module: addsub_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 2, operand width of the adder/subtractor under check.
REQ-002 SHALL have parameter NVEC, default 32, number of vectors per run; the default equals 2^(2*WIDTH+1), i.e. all a/b/cin combinations.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle run request.
REQ-006 SHALL have port vld, input, 1, the a/b/cin/sum/cout sample is valid this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each, the operands applied to the unit under check.
REQ-008 SHALL have port cin, input, 1, the mode/carry input applied to the unit under check.
REQ-009 SHALL have ports sum (input, WIDTH) and cout (input, 1), the unit's response.
REQ-010 SHALL have port busy, output, 1, high in RUN.
REQ-011 SHALL have port done, output, 1, high in DONE.
REQ-012 SHALL have port pass, output, 1, high when done and err_cnt is 0.
REQ-013 SHALL have ports vec_cnt and err_cnt, output, CW = $clog2(NVEC+1) each: vectors checked and mismatches found.
REQ-014 SHALL have ports fail_vld (1), fail_a (WIDTH), fail_b (WIDTH), fail_cin (1), fail_sum (WIDTH) and fail_cout (1), all outputs, forming the first-failure capture.

Function
REQ-015 Expected result SHALL be computed at WIDTH+1 bits as follows: for cin=0, {cout,sum} = a+b; for cin=1, {cout,sum} = a+~b+1, so cout=1 means no borrow.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, start SHALL move the FSM to RUN and clear vec_cnt, err_cnt and fail_vld on the same edge.
REQ-018 In RUN, each edge with vld=1 SHALL compare {cout,sum} against the expected value and increment vec_cnt; err_cnt SHALL increment on a mismatch.
REQ-019 Counter latency SHALL be 1 cycle: the counters reflect a sample on the edge after the one at which it was presented.
REQ-020 In RUN, when a vld sample makes vec_cnt reach NVEC, the FSM SHALL enter DONE on that same edge.
REQ-021 vld SHALL be ignored in IDLE and DONE; start SHALL be ignored in RUN.
REQ-022 In DONE, start SHALL re-enter RUN with cleared counters and capture; otherwise the FSM SHALL hold DONE and all outputs stable.
REQ-023 err_cnt SHALL saturate at NVEC and never wrap.
REQ-024 vld deasserted in RUN SHALL stall: no count changes, no timeout.
REQ-025 If start and vld are both high in IDLE, only start SHALL act; that vld sample is not checked.

Reset
REQ-026 rst SHALL asynchronously force IDLE, busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, fail_vld=0 and all fail_* buses to 0.
REQ-027 rst asserted mid-RUN SHALL abort the run; no partial result is retained.
REQ-028 The first edge after rst deasserts SHALL behave as IDLE.

Configuration
REQ-029 Macro ADDSUB_CHK_FAILCAP_EN SHALL control the first-failure capture.
REQ-030 With the macro defined, the first mismatch in a run SHALL latch a/b/cin/sum/cout into fail_* and set fail_vld; later mismatches SHALL not overwrite the capture.
REQ-031 Without the macro, fail_vld and all fail_* SHALL be constant 0 and no capture registers SHALL exist.

Structure
REQ-032 Package addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the expected-result function from REQ-015.
REQ-033 Sub-module addsub_ref SHALL be the combinational golden model: a, b, cin in; exp_sum, exp_cout out.
REQ-034 The counters, FSM and capture SHALL reside in addsub_checker.

Verification
REQ-035 Exhaustive pass: after start, drive all 32 vectors with correct responses (a=2,b=3,cin=0 -> sum=1,cout=1; a=1,b=2,cin=1 -> sum=3,cout=0) -> done=1, pass=1, vec_cnt=32, err_cnt=0, fail_vld=0.
REQ-036 Single fault: corrupt only vector a=3,b=1,cin=1 (drive sum=0 instead of 2) -> err_cnt=1, pass=0, fail_vld=1, fail_a=3, fail_b=1, fail_cin=1, fail_sum=0, fail_cout=1 (with ADDSUB_CHK_FAILCAP_EN defined).
REQ-037 Stuck cout=0 on every vector -> err_cnt equals the count of vectors whose expected cout=1 (16 for WIDTH=2); capture holds the first such vector.
REQ-038 Stall/ignore: vld low for 10 cycles mid-run -> counts frozen; vld pulses while in IDLE/DONE and start pulses in RUN -> no effect.
REQ-039 Reset mid-run after 7 vectors -> all outputs 0 immediately (asynchronous); a subsequent start plus 32 correct vectors -> pass=1.
REQ-040 Build without the macro and repeat REQ-036 -> err_cnt=1, fail_vld=0 and all fail_* remain 0.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and the golden add/subtract function for the add/sub checker.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Expected {cout,sum} in bits [w:0]; cin=1 selects a + ~b + 1 (cout=1 => no borrow).
  // Operands are widened to 32 bits so one function serves every WIDTH up to 32.
  function automatic logic [32:0] exp_result(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        cin,
                                              input int unsigned w);
    logic [32:0] mask;
    logic [32:0] bop;
    mask = (33'd1 << w) - 33'd1;
    bop  = cin ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    return ({1'b0, a} & mask) + bop + {32'd0, cin};
  endfunction

endpackage

// File: rtl/addsub_checker_ref.sv
// Combinational golden model of the adder/subtractor under check.
module addsub_ref
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_cout
);

  logic [WIDTH:0] res;

  // Evaluate the reference result and split it into sum and carry-out.
  always_comb begin
    res      = (WIDTH+1)'(exp_result(32'(a), 32'(b), cin, WIDTH));
    exp_sum  = res[WIDTH-1:0];
    exp_cout = res[WIDTH];
  end

endmodule

// File: rtl/addsub_checker.sv
// Run controller for checking an adder/subtractor against addsub_ref.
// Define ADDSUB_CHK_FAILCAP_EN to build the first-failure capture registers;
// without it the fail_* outputs are tied to zero.
module addsub_checker
  import addsub_pkg::*;
#(
  parameter  int unsigned WIDTH = 2,
  parameter  int unsigned NVEC  = 32,
  localparam int unsigned CW    = $clog2(NVEC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    vec_cnt,
  output logic [CW-1:0]    err_cnt,
  output logic             fail_vld,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout
);

  state_e           state_q, state_d;
  logic [CW-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]    err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             mismatch;
  logic             restart;
  logic             sample;

  addsub_ref #(.WIDTH(WIDTH)) u_ref (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  assign mismatch = ({cout, sum} != {exp_cout, exp_sum});
  assign restart  = (state_q != RUN) && start;
  assign sample   = (state_q == RUN) && vld;

  // Next-state and counter update; vld outside RUN and start inside RUN are ignored.
  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          vec_cnt_d = '0;
          err_cnt_d = '0;
        end
      end
      RUN: begin
        if (vld) begin
          vec_cnt_d = vec_cnt_q + CW'(1);
          if (mismatch && (err_cnt_q != CW'(NVEC))) begin
            err_cnt_d = err_cnt_q + CW'(1);
          end
          if (vec_cnt_d == CW'(NVEC)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign pass    = done && (err_cnt_q == '0);
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;

`ifdef ADDSUB_CHK_FAILCAP_EN
  logic             fail_vld_q,  fail_vld_d;
  logic [WIDTH-1:0] fail_a_q,    fail_a_d;
  logic [WIDTH-1:0] fail_b_q,    fail_b_d;
  logic             fail_cin_q,  fail_cin_d;
  logic [WIDTH-1:0] fail_sum_q,  fail_sum_d;
  logic             fail_cout_q, fail_cout_d;

  // Latch only the first mismatching sample of a run; a new run clears it.
  always_comb begin
    fail_vld_d  = fail_vld_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_cin_d  = fail_cin_q;
    fail_sum_d  = fail_sum_q;
    fail_cout_d = fail_cout_q;
    if (restart) begin
      fail_vld_d  = 1'b0;
      fail_a_d    = '0;
      fail_b_d    = '0;
      fail_cin_d  = 1'b0;
      fail_sum_d  = '0;
      fail_cout_d = 1'b0;
    end else if (sample && mismatch && !fail_vld_q) begin
      fail_vld_d  = 1'b1;
      fail_a_d    = a;
      fail_b_d    = b;
      fail_cin_d  = cin;
      fail_sum_d  = sum;
      fail_cout_d = cout;
    end
  end

  // Capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vld_q  <= 1'b0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_cin_q  <= 1'b0;
      fail_sum_q  <= '0;
      fail_cout_q <= 1'b0;
    end else begin
      fail_vld_q  <= fail_vld_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_cin_q  <= fail_cin_d;
      fail_sum_q  <= fail_sum_d;
      fail_cout_q <= fail_cout_d;
    end
  end

  assign fail_vld  = fail_vld_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_cin  = fail_cin_q;
  assign fail_sum  = fail_sum_q;
  assign fail_cout = fail_cout_q;
`else
  assign fail_vld  = 1'b0;
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_cin  = 1'b0;
  assign fail_sum  = '0;
  assign fail_cout = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_checker.sv
// Directed testbench for addsub_checker (WIDTH=2, NVEC=32).
module tb_addsub_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] a = '0, b = '0, sum = '0;
  logic       cin = 1'b0, cout = 1'b0;
  logic       busy, done, pass, fail_vld, fail_cin, fail_cout;
  logic [5:0] vec_cnt, err_cnt;
  logic [1:0] fail_a, fail_b, fail_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_checker #(.WIDTH(2), .NVEC(32)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .fail_vld(fail_vld), .fail_a(fail_a), .fail_b(fail_b),
    .fail_cin(fail_cin), .fail_sum(fail_sum), .fail_cout(fail_cout)
  );

  // Bench model: subtraction mode gives a - b + 4 (bit 2 = no borrow).
  function automatic logic [2:0] model(input logic [1:0] ma, input logic [1:0] mb, input logic mc);
    int r;
    r = mc ? (int'(ma) + 4 - int'(mb)) : (int'(ma) + int'(mb));
    return r[2:0];
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; vld = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: correct, 1: corrupt a=3,b=1,cin=1 to sum=0, 2: cout stuck at 0
  task automatic drive_range(input int lo, input int hi, input int mode);
    logic [4:0] v;
    logic [2:0] r;
    for (int i = lo; i < hi; i++) begin
      v = 5'(i);
      r = model(v[4:3], v[2:1], v[0]);
      if (mode == 1 && v == 5'b11011) r[1:0] = 2'd0;
      if (mode == 2) r[2] = 1'b0;
      @(negedge clk);
      vld = 1'b1; a = v[4:3]; b = v[2:1]; cin = v[0]; sum = r[1:0]; cout = r[2];
    end
    @(negedge clk); vld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if ({busy, done, pass, fail_vld} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, fail_vld}); end
    tests++; if (vec_cnt !== 6'd0 || err_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt: got vec=%0d err=%0d expected 0/0", vec_cnt, err_cnt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    @(negedge clk); vld = 1'b1; a = 2'd1; b = 2'd1; cin = 1'b0; sum = 2'd0; cout = 1'b1;
    @(negedge clk); vld = 1'b0;
    tests++; if (busy !== 1'b0 || vec_cnt !== 6'd0) begin fails++; $display("FAIL idle_vld: got busy=%b vec=%0d expected 0/0", busy, vec_cnt); end
    // start with a mismatching vld sample: only start acts
    @(negedge clk); start = 1'b1; vld = 1'b1; a = 2'd1; b = 2'd1; cin = 1'b0; sum = 2'd0; cout = 1'b1;
    @(negedge clk); start = 1'b0; vld = 1'b0;
    tests++; if (busy !== 1'b1 || vec_cnt !== 6'd0 || err_cnt !== 6'd0) begin fails++; $display("FAIL start_vld: got busy=%b vec=%0d err=%0d expected 1/0/0", busy, vec_cnt, err_cnt); end
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    pulse_start();
    tests++; if (busy !== 1'b1 || vec_cnt !== 6'd0) begin fails++; $display("FAIL start_run: got busy=%b vec=%0d expected 1/0", busy, vec_cnt); end
    drive_range(0, 32, 0);
    tests++; if ({done, pass, busy} !== 3'b110) begin fails++; $display("FAIL exh_flags: got done/pass/busy=%b expected 110", {done, pass, busy}); end
    tests++; if (vec_cnt !== 6'd32 || err_cnt !== 6'd0 || fail_vld !== 1'b0) begin fails++; $display("FAIL exh_cnt: got vec=%0d err=%0d fv=%b expected 32/0/0", vec_cnt, err_cnt, fail_vld); end
  endtask

  task automatic test_single_fault();
    pulse_start();
    tests++; if (vec_cnt !== 6'd0 || done !== 1'b0) begin fails++; $display("FAIL restart_clear: got vec=%0d done=%b expected 0/0", vec_cnt, done); end
    drive_range(0, 32, 1);
    tests++; if (err_cnt !== 6'd1 || pass !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL sf_result: got err=%0d pass=%b done=%b expected 1/0/1", err_cnt, pass, done); end
`ifdef ADDSUB_CHK_FAILCAP_EN
    tests++; if ({fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout} !== {1'b1, 2'd3, 2'd1, 1'b1, 2'd0, 1'b1}) begin fails++; $display("FAIL sf_capture: got %b expected 1_11_01_1_00_1", {fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout}); end
`else
    tests++; if ({fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout} !== 9'b0) begin fails++; $display("FAIL sf_nocap: got %b expected all zero", {fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout}); end
`endif
  endtask

  task automatic test_stuck_cout();
    pulse_start();
    drive_range(0, 32, 2);
    tests++; if (err_cnt !== 6'd16 || vec_cnt !== 6'd32 || pass !== 1'b0) begin fails++; $display("FAIL stuck_cnt: got err=%0d vec=%0d pass=%b expected 16/32/0", err_cnt, vec_cnt, pass); end
`ifdef ADDSUB_CHK_FAILCAP_EN
    tests++; if ({fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout} !== {1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0}) begin fails++; $display("FAIL stuck_capture: got %b expected 1_00_00_1_00_0", {fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout}); end
`else
    tests++; if ({fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout} !== 9'b0) begin fails++; $display("FAIL stuck_nocap: got %b expected all zero", {fail_vld, fail_a, fail_b, fail_cin, fail_sum, fail_cout}); end
`endif
  endtask

  task automatic test_stall_ignore();
    // vld in DONE with a wrong response
    @(negedge clk); vld = 1'b1; a = 2'd3; b = 2'd3; cin = 1'b0; sum = 2'd0; cout = 1'b0;
    @(negedge clk); @(negedge clk); vld = 1'b0;
    tests++; if (done !== 1'b1 || vec_cnt !== 6'd32 || err_cnt !== 6'd16) begin fails++; $display("FAIL done_hold: got done=%b vec=%0d err=%0d expected 1/32/16", done, vec_cnt, err_cnt); end
    pulse_start();
    drive_range(0, 5, 0);
    repeat (10) @(negedge clk);
    tests++; if (vec_cnt !== 6'd5 || busy !== 1'b1) begin fails++; $display("FAIL stall: got vec=%0d busy=%b expected 5/1", vec_cnt, busy); end
    pulse_start();
    tests++; if (vec_cnt !== 6'd5 || busy !== 1'b1) begin fails++; $display("FAIL start_in_run: got vec=%0d busy=%b expected 5/1", vec_cnt, busy); end
    drive_range(5, 31, 0);
    tests++; if (vec_cnt !== 6'd31 || busy !== 1'b1) begin fails++; $display("FAIL before_last: got vec=%0d busy=%b expected 31/1", vec_cnt, busy); end
    drive_range(31, 32, 0);
    tests++; if (pass !== 1'b1 || vec_cnt !== 6'd32 || err_cnt !== 6'd0) begin fails++; $display("FAIL stall_pass: got pass=%b vec=%0d err=%0d expected 1/32/0", pass, vec_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    drive_range(0, 3, 1);
    drive_range(27, 31, 1);
    tests++; if (vec_cnt !== 6'd7 || err_cnt !== 6'd1) begin fails++; $display("FAIL pre_abort: got vec=%0d err=%0d expected 7/1", vec_cnt, err_cnt); end
    #1 rst = 1'b1;
    #1;
    tests++; if ({busy, done, pass, fail_vld, vec_cnt, err_cnt} !== 16'b0) begin fails++; $display("FAIL async_rst: got busy=%b done=%b vec=%0d err=%0d fv=%b expected zeros", busy, done, vec_cnt, err_cnt, fail_vld); end
    tests++; if ({fail_a, fail_b, fail_cin, fail_sum, fail_cout} !== 8'b0) begin fails++; $display("FAIL async_rst_cap: got %b expected zeros", {fail_a, fail_b, fail_cin, fail_sum, fail_cout}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || vec_cnt !== 6'd0) begin fails++; $display("FAIL post_rst_idle: got busy=%b vec=%0d expected 0/0", busy, vec_cnt); end
    pulse_start();
    drive_range(0, 32, 0);
    tests++; if (pass !== 1'b1 || vec_cnt !== 6'd32 || fail_vld !== 1'b0) begin fails++; $display("FAIL rerun_pass: got pass=%b vec=%0d fv=%b expected 1/32/0", pass, vec_cnt, fail_vld); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_exhaustive();
    test_single_fault();
    test_stuck_cout();
    test_stall_ignore();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
